// File: rtl/sync_reset_seq_if.sv
// Bundle of the software reset request and the per-channel reset outputs.
// The controller uses the slave view and the requester/consumer uses the master view.
interface sync_reset_seq_if #(
  parameter int NCH = 4
);
  logic           SW_RST;
  logic [NCH-1:0] OUT_RST_N;
  logic           RST_DONE;

  modport master (output SW_RST, input OUT_RST_N, input RST_DONE);
  modport slave  (input SW_RST, output OUT_RST_N, output RST_DONE);
endinterface

// File: rtl/sync_reset_seq.sv
// Multi-channel reset sequencer: asserts every channel reset at once and
// releases the channels one by one, synchronously, after a sync delay and a hold time.
module sync_reset_seq #(
  parameter int RSTDELAY    = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int STAGGER     = 2,
  parameter int NCH         = 4
) (
  input logic              CLK,
  input logic              RST,
  sync_reset_seq_if.slave  bus
);
  localparam int CW = $clog2(NCH) + 1;

  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [15:0]         HOLD_LAST = 16'(HOLD_CYCLES);
  localparam logic [7:0]          STG_LAST  = 8'(STAGGER - 1);
  localparam logic [CW-1:0]       CH_ALL    = CW'(NCH);
  localparam logic [CW-1:0]       CH_INC    = CW'(1);
  localparam logic [NCH-1:0]      CH_ONE    = NCH'(1);
  localparam logic [RSTDELAY-1:0] SYNC_ONE  = RSTDELAY'(1);

  logic [RSTDELAY-1:0] sync_q;
  logic [1:0]          state_q, state_d;
  logic [15:0]         hold_cnt_q, hold_cnt_d;
  logic [7:0]          stag_cnt_q, stag_cnt_d;
  logic [CW-1:0]       ch_idx_q, ch_idx_d;
  logic [NCH-1:0]      out_q, out_d;
  logic                done_q, done_d;

  // The sync chain keeps its ones across software restarts; only RST clears it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= {RSTDELAY{1'b0}};
    end else begin
      sync_q <= (sync_q << 1) | SYNC_ONE;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    stag_cnt_d = stag_cnt_q;
    ch_idx_d   = ch_idx_q;
    out_d      = out_q;
    done_d     = done_q;
    if (bus.SW_RST && (state_q != ST_SYNC)) begin
      state_d    = ST_HOLD;
      hold_cnt_d = 16'd0;
      stag_cnt_d = 8'd0;
      ch_idx_d   = {CW{1'b0}};
      out_d      = {NCH{1'b0}};
      done_d     = 1'b0;
    end else begin
      case (state_q)
        ST_SYNC: begin
          if (sync_q[RSTDELAY-1]) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_SYNC;
          end
        end
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            out_d      = CH_ONE;
            ch_idx_d   = CH_INC;
            stag_cnt_d = 8'd0;
            state_d    = ST_REL;
          end else begin
            hold_cnt_d = hold_cnt_q + 16'd1;
          end
        end
        ST_REL: begin
          // Channels release in index order, so a left shift filling with ones is enough.
          if (ch_idx_q == CH_ALL) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (stag_cnt_q == STG_LAST) begin
            out_d      = (out_q << 1) | CH_ONE;
            ch_idx_d   = ch_idx_q + CH_INC;
            stag_cnt_d = 8'd0;
          end else begin
            stag_cnt_d = stag_cnt_q + 8'd1;
          end
        end
        ST_DONE: begin
          done_d = 1'b1;
        end
        default: begin
          state_d = ST_SYNC;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_SYNC;
      hold_cnt_q <= 16'd0;
      stag_cnt_q <= 8'd0;
      ch_idx_q   <= {CW{1'b0}};
      out_q      <= {NCH{1'b0}};
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      stag_cnt_q <= stag_cnt_d;
      ch_idx_q   <= ch_idx_d;
      out_q      <= out_d;
      done_q     <= done_d;
    end
  end

  assign bus.OUT_RST_N = out_q;
  assign bus.RST_DONE  = done_q;

endmodule

// File: tb/tb_sync_reset_seq.sv
// Directed bench: default-parameter sequencer plus a corner-parameter instance
// sharing clock and reset; expected release edges come from the edge formula.
module tb_sync_reset_seq;
  localparam int RD   = 2;
  localparam int HC   = 4;
  localparam int STG  = 2;
  localparam int NCHD = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   e;
  int   h;

  sync_reset_seq_if #(.NCH(NCHD)) bus_d ();
  sync_reset_seq_if #(.NCH(1))    bus_c ();

  sync_reset_seq #(
    .RSTDELAY(RD), .HOLD_CYCLES(HC), .STAGGER(STG), .NCH(NCHD)
  ) dut (
    .CLK(clk), .RST(rst), .bus(bus_d)
  );

  sync_reset_seq #(
    .RSTDELAY(1), .HOLD_CYCLES(0), .STAGGER(1), .NCH(1)
  ) dut_c (
    .CLK(clk), .RST(rst), .bus(bus_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, e, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_out"},    32'(bus_d.OUT_RST_N), 32'd0);
    check_eq({tag, "_done"},   32'(bus_d.RST_DONE),  32'd0);
    check_eq({tag, "_c_out"},  32'(bus_c.OUT_RST_N), 32'd0);
    check_eq({tag, "_c_done"}, 32'(bus_c.RST_DONE),  32'd0);
  endtask

  task automatic check_edge();
    logic [3:0] exp_out;
    logic       exp_done;
    for (int i = 0; i < NCHD; i++) begin
      exp_out[i] = (e >= h + HC + 1 + i * STG);
    end
    exp_done = (e >= h + HC + 1 + (NCHD - 1) * STG + 1);
    check_eq("out_rst_n", 32'(bus_d.OUT_RST_N), 32'(exp_out));
    check_eq("rst_done",  32'(bus_d.RST_DONE),  32'(exp_done));
    check_eq("c_out_rst_n", 32'(bus_c.OUT_RST_N), (e >= 3) ? 32'd1 : 32'd0);
    check_eq("c_rst_done",  32'(bus_c.RST_DONE),  (e >= 4) ? 32'd1 : 32'd0);
  endtask

  task automatic run_to(input int last);
    while (e < last) begin
      tick();
      check_edge();
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    e   = 0;
    h   = RD + 1;
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    e            = 0;
    h            = RD + 1;
    rst          = 1'b1;
    bus_d.SW_RST = 1'b0;
    bus_c.SW_RST = 1'b0;

    // power-on: outputs held low throughout the RST pulse
    repeat (3) begin
      @(posedge clk);
      #1;
      check_zero("por_hold");
    end
    release_rst();
    run_to(19);

    // single-cycle software request sampled at edge 20
    bus_d.SW_RST = 1'b1;
    tick();
    h = e;
    check_edge();
    check_eq("sw_edge20_out", 32'(bus_d.OUT_RST_N), 32'd0);
    bus_d.SW_RST = 1'b0;
    run_to(33);
    check_eq("sw_done33", 32'(bus_d.RST_DONE), 32'd1);

    // asynchronous assertion between clock edges
    #3;
    rst = 1'b1;
    #1;
    check_zero("async_assert");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_zero("async_hold");
    end

    // mid-sequence reset at edge 11
    release_rst();
    run_to(11);
    check_eq("mid_edge11_out", 32'(bus_d.OUT_RST_N), 32'h3);
    rst = 1'b1;
    #1;
    check_zero("mid_assert");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_zero("mid_hold");
    end

    // full power-on timing repeats, then sustained software request on edges 20..24
    release_rst();
    run_to(19);
    bus_d.SW_RST = 1'b1;
    repeat (5) begin
      tick();
      h = e;
      check_edge();
      check_eq("sw_hold_out", 32'(bus_d.OUT_RST_N), 32'd0);
    end
    bus_d.SW_RST = 1'b0;
    run_to(28);
    check_eq("sus_edge28_out", 32'(bus_d.OUT_RST_N), 32'd0);
    run_to(29);
    check_eq("sus_edge29_out", 32'(bus_d.OUT_RST_N), 32'h1);
    run_to(35);
    check_eq("sus_edge35_done", 32'(bus_d.RST_DONE), 32'd0);
    run_to(36);
    check_eq("sus_edge36_done", 32'(bus_d.RST_DONE), 32'd1);
    run_to(38);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
